// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezes with timeout, and a saturating count of stalled PC cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_RegDst,
  input  logic             Branch_Taken,
  input  logic             Mem_Req,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Count
);

  // Wait counter just wide enough to hold MEM_TIMEOUT.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    ERR        = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              mem_stall_c;
  logic              load_use_c;
  logic [WAIT_W-1:0] wait_inc_c;

  // Hazard detection terms shared by several states.
  always_comb begin
    mem_stall_c = Mem_Req & ~Mem_Ready;
    load_use_c  = EX_MemRead & EX_RegWrite & (EX_RegDst != 5'd0) &
                  ((EX_RegDst == ID_Rs) | (ID_UsesRt & (EX_RegDst == ID_Rt)));
    wait_inc_c  = wait_q + WAIT_W'(1);
  end

  // Next-state and Mealy outputs; reset forces the safe output pattern.
  always_comb begin
    logic freeze;
    logic run_rules;
    logic flush_only;

    state_d       = state_q;
    wait_d        = wait_q;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    Mem_Err       = 1'b0;
    freeze        = 1'b0;
    run_rules     = 1'b0;
    flush_only    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall_c) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          run_rules = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (mem_stall_c) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          state_d    = RUN;
          flush_only = Branch_Taken;
        end
      end
      MEM_WAIT: begin
        if (!Mem_Ready) begin
          freeze = 1'b1;
          wait_d = wait_inc_c;
          if (wait_inc_c >= WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
          end
        end else begin
          run_rules = 1'b1;
        end
      end
      ERR: begin
        freeze  = 1'b1;
        Mem_Err = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Branch beats load-use; the taken branch kills the dependent instruction.
    if (run_rules) begin
      state_d = RUN;
      if (Branch_Taken) begin
        flush_only = 1'b1;
      end else if (load_use_c) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        state_d      = LOAD_STALL;
      end
    end

    if (flush_only) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end

    if (freeze) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end

    if (!Reset) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Write   = 1'b0;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
      Mem_Err       = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter and stall counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [6:0] EXP_RST = 7'b0000101;
  localparam logic [6:0] EXP_DEF = 7'b1101010;
  localparam logic [6:0] EXP_LU  = 7'b0001110;
  localparam logic [6:0] EXP_FRZ = 7'b0000001;
  localparam logic [6:0] EXP_BR  = 7'b1111110;

  logic          Clk, Reset;
  logic [4:0]    ID_Rs, ID_Rt, EX_RegDst;
  logic          ID_UsesRt, EX_MemRead, EX_RegWrite, Branch_Taken, Mem_Req, Mem_Ready;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
  logic          EX_MEM_Write, MEM_WB_Bubble, Mem_Err;
  logic [CW-1:0] Stall_Count;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RegDst(EX_RegDst),
    .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Bubble(MEM_WB_Bubble), .Mem_Err(Mem_Err), .Stall_Count(Stall_Count)
  );

  assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
                 EX_MEM_Write, MEM_WB_Bubble};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_RegDst = 5'd0;
    Branch_Taken = 1'b0; Mem_Req = 1'b0; Mem_Ready = 1'b0;
  endtask

  task automatic set_lu();
    idle();
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RegDst = 5'd5; ID_Rs = 5'd5;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    idle();
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    idle();
    #2 Reset = 1'b0;
    #1;
    checks++; if (outs !== EXP_RST) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, EXP_RST); end
    checks++; if (Stall_Count !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", Stall_Count); end
    checks++; if (Mem_Err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", Mem_Err); end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, EXP_DEF); end
  endtask

  task automatic test_load_use();
    apply_reset();
    @(negedge Clk); set_lu(); #1;
    checks++; if (outs !== EXP_LU) begin errors++; $display("FAIL lu_rs got=%b exp=%b", outs, EXP_LU); end
    @(negedge Clk); #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL lu_one_cycle got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); idle(); #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL lu_back_run got=%b exp=%b", outs, EXP_DEF); end
    checks++; if (Stall_Count !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", Stall_Count); end
    @(negedge Clk); set_lu(); ID_Rs = 5'd3; ID_Rt = 5'd5; ID_UsesRt = 1'b1; #1;
    checks++; if (outs !== EXP_LU) begin errors++; $display("FAIL lu_rt got=%b exp=%b", outs, EXP_LU); end
    @(negedge Clk); idle(); #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL lu_rt_release got=%b exp=%b", outs, EXP_DEF); end
  endtask

  task automatic test_no_stall();
    apply_reset();
    @(negedge Clk); set_lu(); EX_RegDst = 5'd0; ID_Rs = 5'd0; #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL ns_reg0 got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); set_lu(); EX_RegDst = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_UsesRt = 1'b0; #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL ns_rt_unused got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); set_lu(); EX_RegWrite = 1'b0; #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL ns_no_regwrite got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); idle(); Mem_Req = 1'b1; Mem_Ready = 1'b1; #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL ns_mem_ready got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); idle(); #1;
    checks++; if (Stall_Count !== 4'd0) begin errors++; $display("FAIL ns_cnt got=%0d exp=0", Stall_Count); end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); idle(); Mem_Req = 1'b1; Mem_Ready = 1'b0; #1;
      checks++; if (outs !== EXP_FRZ) begin errors++; $display("FAIL mw_freeze%0d got=%b exp=%b", i, outs, EXP_FRZ); end
    end
    @(negedge Clk); Mem_Ready = 1'b1; #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL mw_release got=%b exp=%b", outs, EXP_DEF); end
    @(negedge Clk); idle(); #1;
    checks++; if (Stall_Count !== 4'd3) begin errors++; $display("FAIL mw_cnt got=%0d exp=3", Stall_Count); end
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL mw_run got=%b exp=%b", outs, EXP_DEF); end
  endtask

  task automatic test_mem_exit_load_use();
    apply_reset();
    @(negedge Clk); idle(); Mem_Req = 1'b1; #1;
    checks++; if (outs !== EXP_FRZ) begin errors++; $display("FAIL mx_freeze got=%b exp=%b", outs, EXP_FRZ); end
    @(negedge Clk); set_lu(); Mem_Req = 1'b1; Mem_Ready = 1'b1; #1;
    checks++; if (outs !== EXP_LU) begin errors++; $display("FAIL mx_exit_lu got=%b exp=%b", outs, EXP_LU); end
    @(negedge Clk); set_lu(); #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL mx_load_stall got=%b exp=%b", outs, EXP_DEF); end
    checks++; if (Stall_Count !== 4'd2) begin errors++; $display("FAIL mx_cnt got=%0d exp=2", Stall_Count); end
    @(negedge Clk); idle(); Mem_Req = 1'b1; #1;
    checks++; if (outs !== EXP_FRZ) begin errors++; $display("FAIL mx_refreeze got=%b exp=%b", outs, EXP_FRZ); end
  endtask

  task automatic test_branch();
    apply_reset();
    @(negedge Clk); set_lu(); Branch_Taken = 1'b1; #1;
    checks++; if (outs !== EXP_BR) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", outs, EXP_BR); end
    @(negedge Clk); set_lu(); #1;
    checks++; if (outs !== EXP_LU) begin errors++; $display("FAIL br_no_load_stall got=%b exp=%b", outs, EXP_LU); end
    checks++; if (Stall_Count !== 4'd0) begin errors++; $display("FAIL br_cnt got=%0d exp=0", Stall_Count); end
    @(negedge Clk); set_lu(); Branch_Taken = 1'b1; #1;
    checks++; if (outs !== EXP_BR) begin errors++; $display("FAIL br_in_load_stall got=%b exp=%b", outs, EXP_BR); end
    @(negedge Clk); idle(); Branch_Taken = 1'b1; Mem_Req = 1'b1; #1;
    checks++; if (outs !== EXP_FRZ) begin errors++; $display("FAIL br_mem_priority got=%b exp=%b", outs, EXP_FRZ); end
    @(negedge Clk); Mem_Ready = 1'b1; #1;
    checks++; if (outs !== EXP_BR) begin errors++; $display("FAIL br_mem_exit got=%b exp=%b", outs, EXP_BR); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i <= int'(TO); i++) begin
      @(negedge Clk); idle(); Mem_Req = 1'b1; #1;
      checks++; if (outs !== EXP_FRZ || Mem_Err !== 1'b0) begin errors++; $display("FAIL to_wait%0d got=%b err=%b exp=%b err=0", i, outs, Mem_Err, EXP_FRZ); end
    end
    @(negedge Clk); #1;
    checks++; if (Mem_Err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", Mem_Err); end
    @(negedge Clk); idle(); Mem_Ready = 1'b1; Branch_Taken = 1'b1; #1;
    checks++; if (outs !== EXP_FRZ || Mem_Err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b err=%b exp=%b err=1", outs, Mem_Err, EXP_FRZ); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (outs !== EXP_RST || Mem_Err !== 1'b0 || Stall_Count !== 4'd0) begin errors++; $display("FAIL to_async_clear got=%b err=%b cnt=%0d exp=%b err=0 cnt=0", outs, Mem_Err, Stall_Count, EXP_RST); end
    @(negedge Clk); Reset = 1'b1; idle(); #1;
    checks++; if (outs !== EXP_DEF) begin errors++; $display("FAIL to_after_reset got=%b exp=%b", outs, EXP_DEF); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    @(negedge Clk); idle(); Mem_Req = 1'b1;
    @(negedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1; set_lu(); #1;
    checks++; if (outs !== EXP_LU) begin errors++; $display("FAIL rm_from_run got=%b exp=%b", outs, EXP_LU); end
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge Clk); set_lu();
    repeat (28) @(negedge Clk);
    #1;
    checks++; if (Stall_Count !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d exp=14", Stall_Count); end
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (Stall_Count !== 4'd15) begin errors++; $display("FAIL sat_15 got=%0d exp=15", Stall_Count); end
    repeat (10) @(negedge Clk);
    #1;
    checks++; if (Stall_Count !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", Stall_Count); end
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_mem_wait();
    test_mem_exit_load_use();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before the error state.
- CNT_W, 16, width of Stall_Count.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clk, in, 1, single clock; all state updates on its posedge.
- Reset, in, 1, asynchronous, active-low reset.
- ID_Rs, in, 5, source register 1 of the ID-stage instruction.
- ID_Rt, in, 5, source register 2 of the ID-stage instruction.
- ID_UsesRt, in, 1, ID-stage instruction reads Rt.
- EX_MemRead, in, 1, EX-stage instruction is a load.
- EX_RegWrite, in, 1, EX-stage instruction writes a register.
- EX_RegDst, in, 5, EX-stage destination register.
- Branch_Taken, in, 1, branch resolved taken in EX.
- Mem_Req, in, 1, MEM stage is accessing data memory.
- Mem_Ready, in, 1, data memory completes the access this cycle.
- PC_Write, out, 1, PC update enable.
- IF_ID_Write, out, 1, IF/ID register enable.
- IF_ID_Flush, out, 1, IF/ID register loads a NOP.
- ID_EX_Write, out, 1, ID/EX register enable.
- ID_EX_Bubble, out, 1, ID/EX register loads zero control.
- EX_MEM_Write, out, 1, EX/MEM register enable.
- MEM_WB_Bubble, out, 1, MEM/WB register loads zero control: RegWrite=0, MemToReg=0, halfbyte=0.
- Mem_Err, out, 1, sticky memory-timeout flag.
- Stall_Count, out, CNT_W, count of cycles with PC_Write=0.

Function
REQ-003 The block SHALL have the states RUN, LOAD_STALL, MEM_WAIT and ERR. Outputs SHALL be combinational in state and inputs (Mealy).
REQ-004 Default outputs SHALL be: all *_Write=1; IF_ID_Flush, ID_EX_Bubble and MEM_WB_Bubble=0.
REQ-005 A memory stall SHALL be detected in RUN or LOAD_STALL when Mem_Req=1 and Mem_Ready=0.
- Outputs: PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write=0; MEM_WB_Bubble=1.
- Next state: MEM_WAIT.
- Priority: highest.
REQ-006 A load-use hazard SHALL be detected in RUN when all of the following hold: EX_MemRead=1, EX_RegWrite=1, EX_RegDst!=0, and either EX_RegDst==ID_Rs or (ID_UsesRt=1 and EX_RegDst==ID_Rt).
- Outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
- Next state: LOAD_STALL.
REQ-007 Branch_Taken=1 in RUN, LOAD_STALL, or the MEM_WAIT exit cycle SHALL drive IF_ID_Flush=1 and ID_EX_Bubble=1. It SHALL override load-use for that cycle: PC_Write=1, no transition to LOAD_STALL.
REQ-008 LOAD_STALL SHALL last exactly one cycle and then go to RUN. Load-use SHALL NOT be re-evaluated in LOAD_STALL.
REQ-009 MEM_WAIT SHALL hold the freeze outputs of REQ-005 while Mem_Ready=0.
REQ-010 MEM_WAIT exit: in the cycle Mem_Ready=1, the block SHALL use RUN output rules.
- MEM_WB_Bubble=0.
- Load-use and branch are evaluated as in RUN.
- Next state: LOAD_STALL if load-use is detected, else RUN.
REQ-011 A wait counter SHALL be cleared on MEM_WAIT entry and increment each MEM_WAIT cycle with Mem_Ready=0. When it reaches MEM_TIMEOUT, the next state SHALL be ERR.
REQ-012 ERR SHALL hold the freeze outputs of REQ-005 and Mem_Err=1 until Reset. All inputs SHALL be ignored in ERR.
REQ-013 Stall_Count SHALL increment on each posedge where PC_Write=0, and saturate at all ones.
REQ-014 Mem_Req and Mem_Ready both 1 in RUN SHALL cause no stall.

Reset
REQ-015 Reset=0 SHALL immediately, without waiting for Clk, force:
- state RUN, wait counter 0, Stall_Count 0, Mem_Err 0;
- PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write=0;
- IF_ID_Flush=0, ID_EX_Bubble=1, MEM_WB_Bubble=1.
REQ-016 Reset asserted in any state, including mid-MEM_WAIT or ERR, SHALL abandon the operation. After Reset rises, the first edge SHALL evaluate from RUN.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load-use: EX_MemRead=1, EX_RegWrite=1, EX_RegDst=5, ID_Rs=5 -> one cycle PC_Write=0, ID_EX_Bubble=1; then RUN; Stall_Count=1.
- Load to $0 or no match: EX_RegDst=0, ID_Rs=0; or ID_UsesRt=0 with Rt matching only -> no stall.
- Memory wait: Mem_Req=1, Mem_Ready=0 for 3 cycles, then 1 -> freeze and MEM_WB_Bubble=1 for 3 cycles; release on the 4th; Stall_Count=3.
- Branch with hazard: Branch_Taken=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1, no LOAD_STALL.
- Timeout: MEM_TIMEOUT=4, Mem_Ready held 0 -> ERR after 4 wait cycles, Mem_Err=1 and sticky; Reset=0 clears asynchronously.
- Saturation: CNT_W=4 with 20 stall cycles -> Stall_Count=15.
